// File: rtl/instr_sequencer_pkg.sv
// Shared encodings for the instruction sequencer: fixed instruction words,
// sequencer states and halt cause codes.
package instr_sequencer_pkg;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] ECALL  = 32'h00000073;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  localparam logic [1:0] HALT_SYS       = 2'd0;
  localparam logic [1:0] HALT_SELF_LOOP = 2'd1;
  localparam logic [1:0] HALT_RANGE     = 2'd2;
  localparam logic [1:0] HALT_TIMEOUT   = 2'd3;

endpackage

// File: rtl/instr_mem.sv
// Program memory: one synchronous write port, one asynchronous read port.
// Contents are not reset.
module instr_mem #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/sequencing controller: feeds the single-cycle core from a loadable
// program memory, follows taken branches and stops on the first halt condition.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = 6,
  parameter int MAX_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic [31:0]       instr,
  input  logic              branch_taken,
  output logic [ADDR_W+1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [15:0]       cycle_count,
  output seq_state_e        state_dbg
);

  localparam int PW         = ADDR_W + 2;
  localparam int IMEM_BYTES = 4 * IMEM_DEPTH;

  seq_state_e state;
  logic [31:0] mem_rdata;

  // Loads are only honoured outside RUN so a running program cannot be modified.
  instr_mem #(.DEPTH(IMEM_DEPTH), .AW(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (load_we && (state != SEQ_RUN)),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc[ADDR_W+1:2]),
    .rdata (mem_rdata)
  );

  assign instr     = (state == SEQ_RUN) ? mem_rdata : NOP;
  assign state_dbg = state;

  logic        taken;
  logic [12:0] imm_b;
  logic signed [31:0] pc_ext, imm_ext, next_full;
  logic        range_bad;
  logic        halt;
  logic [1:0]  cause;

  assign taken   = (instr[6:0] == OPC_BRANCH) && branch_taken;
  assign imm_b   = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign pc_ext  = {{(32-PW){1'b0}}, pc};
  assign imm_ext = {{19{imm_b[12]}}, imm_b};

  // Next PC is formed wide so a wrap past either end of memory is visible.
  assign next_full = taken ? (pc_ext + imm_ext) : (pc_ext + 32'sd4);
  assign range_bad = (next_full < 0) || (next_full > IMEM_BYTES - 1) || (taken && imm_b[1]);

  always_comb begin
    halt  = 1'b1;
    cause = HALT_SYS;
    if ((instr == EBREAK) || (instr == ECALL))             cause = HALT_SYS;
    else if (taken && (imm_b == 13'd0))                    cause = HALT_SELF_LOOP;
    else if (range_bad)                                    cause = HALT_RANGE;
    else if (({16'd0, cycle_count} + 32'd1) == 32'(MAX_CYCLES)) cause = HALT_TIMEOUT;
    else                                                   halt  = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEQ_IDLE;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      halt_cause  <= HALT_SYS;
      cycle_count <= '0;
    end else begin
      case (state)
        SEQ_IDLE, SEQ_DONE: begin
          if (start) begin
            state       <= SEQ_RUN;
            pc          <= '0;
            cycle_count <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        SEQ_RUN: begin
          if (cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
          if (halt) begin
            state      <= SEQ_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            halt_cause <= cause;
          end else begin
            pc <= next_full[PW-1:0];
          end
        end
        default: begin
          state <= SEQ_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction fetch/sequencing controller for riscv_simple.
- Holds a small loadable instruction memory and the program counter, and drives the core's instr input each cycle.
- Redirects PC on taken branches using the core's branch_taken output, and stops on EBREAK/ECALL, on a self-loop, on an out-of-range PC or on a cycle-budget timeout.
- Sits between the top level or bench (program load, start) and the single-cycle datapath.

Parameters:
- IMEM_DEPTH, 64, instruction words in the program memory; power of two.
- ADDR_W, 6, word-address width; must equal log2(IMEM_DEPTH).
- MAX_CYCLES, 1024, run-cycle budget before forced timeout halt.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins execution at PC 0.
- load_we  in  1  program-memory write strobe.
- load_addr  in  ADDR_W  word address for load.
- load_data  in  32  instruction word to load.
- instr  out  32  instruction presented to the core this cycle.
- branch_taken  in  1  core branch comparison result for the current instr (combinational, same cycle).
- pc  out  ADDR_W+2  current byte PC.
- busy  out  1  high in RUN.
- done  out  1  high in DONE, sticky.
- halt_cause  out  2  cause of halt: 0 = EBREAK/ECALL, 1 = self-loop, 2 = PC out of range, 3 = timeout.
- cycle_count  out  16  instructions issued in the current/last run.

Behaviour:
- Reset (async, rst_n=0): state IDLE; pc=0, busy=0, done=0, halt_cause=0, cycle_count=0; instr=NOP (32'h00000013). Memory contents are not reset.
- States are IDLE, RUN and DONE.
- IDLE:
  - instr=NOP.
  - load_we writes mem[load_addr]=load_data at the clock edge.
  - start -> RUN with pc=0 and cycle_count=0.
- RUN:
  - instr=mem[pc[ADDR_W+1:2]] combinationally, so the core executes it this cycle.
  - load_we and start are ignored.
- Next-PC, decided at the clock edge in RUN:
  - If opcode=7'b1100011 and branch_taken=1: next pc = pc + sext(imm_b), where imm_b = {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}, computed modulo 2^(ADDR_W+2).
  - Otherwise: next pc = pc+4.
  - cycle_count increments by 1 per RUN cycle and saturates at 16'hFFFF.
- Halt checks in RUN, evaluated in priority order; the current instr still executes in the core that cycle; next state is DONE, pc holds, done=1, busy=0.
  1. instr==32'h00100073 or instr==32'h00000073 -> cause 0.
  2. Taken branch with imm_b==0 -> cause 1.
  3. Computed next pc wraps past the top of memory (pc+4 or pc+imm_b is outside [0, 4*IMEM_DEPTH-1] before truncation), or the branch target is misaligned (imm_b[1]=1) -> cause 2.
  4. cycle_count+1 == MAX_CYCLES -> cause 3.
- DONE:
  - instr=NOP; done, halt_cause, pc and cycle_count hold.
  - load_we is accepted.
  - start -> RUN from pc=0, clearing done and cycle_count.
- Simultaneous load_we and start in IDLE/DONE: the write completes and the run starts next cycle. The written word is visible at fetch, since memory is written at the same edge.
- Reset mid-RUN: immediate return to IDLE with reset values; the next start re-runs from 0.
- Latency: start -> first non-NOP instr on the next cycle; halt -> done high on the edge after the halting instr.

Decomposition:
- The shared defines include gains:
  - NOP, EBREAK and ECALL encodings.
  - OPC_BRANCH.
  - State encodings SEQ_IDLE/SEQ_RUN/SEQ_DONE.
  - HALT_* cause codes.
- One sub-module, instr_mem: IMEM_DEPTH x 32, synchronous write, asynchronous read.

Test Plan:
- Load ADDI x1,x0,5; ADDI x2,x0,10; ADD x3,x1,x2; EBREAK; pulse start -> instr sequence 00500093, 00A00113, 002081B3, 00100073 at pc 0,4,8,12; core aluresult=15 at pc 8; done=1, halt_cause=0, cycle_count=4.
- Load x1=5, x2=10, BEQ x1,x2,+8 (32'h00208463), ADDI x4,x0,1, EBREAK, EBREAK; start -> branch not taken, pc passes 8->12->16; halt_cause=0, cycle_count=5.
- Same program with x2=5 -> branch taken, pc goes 8->16, skipping 12; cycle_count=4.
- Load x1=5, x2=5, BEQ x1,x2,0 (32'h00208063) -> branch_taken=1 at pc 8; halt_cause=1, pc holds 8, done=1.
- MAX_CYCLES=8 with a memory of all NOPs -> done after 8 issued instrs, halt_cause=3; rst_n low mid-run at cycle 3 -> busy=0, pc=0, instr=NOP immediately (asynchronous).
- load_we pulses during RUN -> memory unchanged, verified by a subsequent rerun; start during RUN -> no restart, pc continues.
